plru_alloc_ctrl: RTL and testbench
==================================

PLRU_ALLOC_CTRL -- requirements
Module: plru_alloc_ctrl

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of allocatable entries (power of two, >=2).
REQ-002 SHALL have derived localparam IDX_W = $clog2(ENTRIES), the index width.
REQ-003 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port alloc_req_i  input  1  allocation request, held high until granted.
REQ-006 SHALL have port alloc_gnt_o  output  1  one-cycle grant pulse.
REQ-007 SHALL have port alloc_idx_o  output  IDX_W  granted entry index, valid only with alloc_gnt_o.
REQ-008 SHALL have port hit_i  input  ENTRIES  lookup-hit vector, one bit per entry, marks entries recently used.
REQ-009 SHALL have port inval_i  input  ENTRIES  per-entry invalidate strobes.
REQ-010 SHALL have port flush_i  input  1  single-cycle request to invalidate all entries.
REQ-011 SHALL have port flush_done_o  output  1  one-cycle pulse when flush completes.
REQ-012 SHALL have port valid_o  output  ENTRIES  registered per-entry valid bits.
REQ-013 SHALL have port full_o / empty_o  output  1 each  all / no entries valid, combinational from valid_o.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, FLUSH.
REQ-015 In IDLE with alloc_req_i=1 and no flush pending, SHALL register victim index and go to GRANT.
REQ-016 Victim SHALL be lowest-index entry with valid=0; only if full_o=1, the one-hot PLRU output converted to an index.
REQ-017 In GRANT, SHALL assert alloc_gnt_o=1 for exactly one cycle with the registered index, set valid_o[idx], then return to IDLE.
REQ-018 Request-to-grant latency SHALL be 1 cycle; maximum throughput SHALL be one grant per 2 cycles.
REQ-019 Used vector to PLRU tree SHALL be (hit_i & valid_o) OR one-hot(alloc_idx_o) when alloc_gnt_o=1; hits on invalid entries SHALL be ignored.
REQ-020 inval_i SHALL clear matching valid bits on the next edge in any state; PLRU state SHALL NOT change on invalidate.
REQ-021 Same-cycle grant set and inval_i for the same entry: the set SHALL win (entry valid).
REQ-022 flush_i SHALL be latched as pending; it SHALL take effect from IDLE, or after completion of an in-progress GRANT.
REQ-023 flush_i and alloc_req_i high together in IDLE: flush SHALL win; the request SHALL be served after flush completes.
REQ-024 FLUSH SHALL clear one valid bit per cycle via an IDX_W counter from 0 up to ENTRIES-1, taking ENTRIES cycles, then pulse flush_done_o and return to IDLE.
REQ-025 During FLUSH, alloc_gnt_o SHALL stay 0 and hit_i SHALL be ignored; further flush_i SHALL be absorbed (no second flush).
REQ-026 The victim SHALL be registered from the IDLE-cycle state; invalidates arriving in the GRANT cycle SHALL NOT alter the granted index.

Reset
REQ-027 Asserting rst_ni low SHALL asynchronously force state IDLE, valid_o=0, alloc_gnt_o=0, alloc_idx_o=0, flush_done_o=0, flush pending=0, flush counter=0, PLRU tree bits=0, so empty_o=1 and full_o=0.
REQ-028 Reset mid-GRANT or mid-FLUSH SHALL abort the operation with no grant or done pulse emitted.

Structure
REQ-029 The FSM state enum SHALL be defined in shared package plru_alloc_pkg.
REQ-030 The one-hot-to-index function SHALL be defined in shared package plru_alloc_pkg.
REQ-031 SHALL instantiate exactly one sub-module, plru_tree, with ENTRIES passed through, fed by the REQ-019 used vector, and its plru output used for the victim.

Verification
REQ-032 ENTRIES=4, after reset, alloc_req_i held: grants SHALL have idx 0,1,2,3 on cycles 2,4,6,8; then full_o=1.
REQ-033 Following REQ-032, a 5th request SHALL be granted idx 0 (PLRU), and a 6th request SHALL be granted idx 2.
REQ-034 Full, inval_i=4'b0100 then request: SHALL grant idx 2 (invalid preferred over PLRU), and full_o SHALL return to 1.
REQ-035 flush_i together with alloc_req_i in IDLE: flush_done_o SHALL pulse 4 cycles later with valid_o=0, then a grant of idx 0 SHALL follow.
REQ-036 Same-cycle grant of idx 1 with inval_i[1]=1: valid_o[1] SHALL be 1 afterwards.
REQ-037 rst_ni low mid-FLUSH: all outputs SHALL be at reset values immediately, with no flush_done_o pulse.

Source files
------------

// File: rtl/plru_alloc_pkg.sv
// plru_alloc_pkg: shared FSM state type and one-hot helper for the PLRU allocator
package plru_alloc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int unsigned MAX_ENTRIES = 64;

  function automatic int unsigned onehot_to_idx(input logic [MAX_ENTRIES-1:0] oh);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < MAX_ENTRIES; i++) r = oh[i] ? (r | i) : r;
    return r;
  endfunction

endpackage

// File: rtl/plru_alloc_ctrl_tree.sv
// plru_tree: binary tree pseudo-LRU, each node bit points at the less recently used half
module plru_tree #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [ENTRIES-1:0] used_i,
  output logic [ENTRIES-1:0] plru_o
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-2:0] tree_q, tree_d;
  logic [IDX_W-1:0]   vic;

  // every used entry steers its path away from itself; higher indices applied last
  always_comb begin
    tree_d = tree_q;
    for (int unsigned e = 0; e < ENTRIES; e++)
      if (used_i[e])
        for (int unsigned l = 0; l < IDX_W; l++)
          tree_d[(1 << l) - 1 + (e >> (IDX_W - l))] = ~e[IDX_W-1-l];
  end

  // follow the node bits from the root down to the least recently used leaf
  always_comb begin
    int unsigned node;
    node = 0;
    vic  = '0;
    for (int unsigned l = 0; l < IDX_W; l++) begin
      vic[IDX_W-1-l] = tree_q[node];
      node = 2 * node + 1 + int'(tree_q[node]);
    end
    plru_o = ENTRIES'(1) << vic;
  end

  // tree state register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) tree_q <= '0;
    else tree_q <= tree_d;

endmodule

// File: rtl/plru_alloc_ctrl.sv
// plru_alloc_ctrl: entry allocator preferring free entries, falling back to tree PLRU, with sequential flush
module plru_alloc_ctrl
  import plru_alloc_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       alloc_req_i,
  output logic                       alloc_gnt_o,
  output logic [$clog2(ENTRIES)-1:0] alloc_idx_o,
  input  logic [ENTRIES-1:0]         hit_i,
  input  logic [ENTRIES-1:0]         inval_i,
  input  logic                       flush_i,
  output logic                       flush_done_o,
  output logic [ENTRIES-1:0]         valid_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, cnt_q, cnt_d, first_free, victim;
  logic [ENTRIES-1:0] valid_q, valid_d, used, plru;
  logic               pend_q, pend_d, done_q, done_d;

  assign alloc_gnt_o  = state_q == ST_GRANT;
  assign alloc_idx_o  = idx_q;
  assign flush_done_o = done_q;
  assign valid_o      = valid_q;
  assign full_o       = &valid_q;
  assign empty_o      = ~|valid_q;
  assign used         = state_q == ST_FLUSH ? '0
                      : (hit_i & valid_q) | (alloc_gnt_o ? ENTRIES'(1) << idx_q : '0);

  plru_tree #(.ENTRIES(ENTRIES)) u_tree (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .used_i (used),
    .plru_o (plru)
  );

  // lowest free entry wins; the PLRU leaf only matters once every entry is valid
  always_comb begin
    first_free = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) first_free = valid_q[i] ? first_free : IDX_W'(i);
    victim = full_o ? IDX_W'(onehot_to_idx(MAX_ENTRIES'(plru))) : first_free;
  end

  // sequencing: pending flush beats a request, grant sets its entry over any invalidate
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    pend_d  = pend_q | flush_i;
    valid_d = valid_q & ~inval_i;
    if (state_q == ST_IDLE) begin
      if (pend_d) begin
        state_d = ST_FLUSH;
        pend_d  = 1'b0;
        cnt_d   = '0;
      end else if (alloc_req_i) begin
        state_d = ST_GRANT;
        idx_d   = victim;
      end
    end else if (state_q == ST_GRANT) begin
      valid_d[idx_q] = 1'b1;
      state_d        = ST_IDLE;
    end else begin
      pend_d         = 1'b0;
      valid_d[cnt_q] = 1'b0;
      cnt_d          = cnt_q + 1'b1;
      done_d         = cnt_q == IDX_W'(ENTRIES - 1);
      state_d        = done_d ? ST_IDLE : ST_FLUSH;
    end
  end

  // controller state registers
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end

endmodule

// File: tb/tb_plru_alloc_ctrl.sv
// tb_plru_alloc_ctrl: directed scenarios plus randomized run against a behavioural allocator model
module tb_plru_alloc_ctrl;
  localparam int N = 4;

  logic         clk_i = 1'b0, rst_ni = 1'b0, alloc_req_i = 1'b0, flush_i = 1'b0;
  logic [N-1:0] hit_i = '0, inval_i = '0;
  logic         alloc_gnt_o, flush_done_o, full_o, empty_o;
  logic [1:0]   alloc_idx_o;
  logic [N-1:0] valid_o;
  logic [9:0]   obs;
  int           checks = 0, errors = 0;

  localparam logic [9:0] RST_OBS = 10'b0_00_0_0000_0_1;

  plru_alloc_ctrl #(.ENTRIES(N)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .alloc_req_i  (alloc_req_i),
    .alloc_gnt_o  (alloc_gnt_o),
    .alloc_idx_o  (alloc_idx_o),
    .hit_i        (hit_i),
    .inval_i      (inval_i),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .valid_o      (valid_o),
    .full_o       (full_o),
    .empty_o      (empty_o)
  );

  assign obs = {alloc_gnt_o, alloc_idx_o, flush_done_o, valid_o, full_o, empty_o};

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // behavioural model: valid set, tree PLRU as "which half is older" flags, flush countdown
  logic [N-1:0] mv;
  bit           m_busy, m_pend, m_done, old_right_root, old_right_lo, old_right_hi;
  int           m_gidx, m_left;

  function automatic int m_victim();
    for (int e = 0; e < N; e++) if (!mv[e]) return e;
    return old_right_root ? (old_right_hi ? 3 : 2) : (old_right_lo ? 1 : 0);
  endfunction

  task automatic m_touch(input int e);
    if (e < 2) begin
      old_right_root = 1;
      old_right_lo   = (e == 0);
    end else begin
      old_right_root = 0;
      old_right_hi   = (e == 2);
    end
  endtask

  task automatic m_reset();
    mv = '0; m_busy = 0; m_pend = 0; m_done = 0; m_gidx = 0; m_left = 0;
    old_right_root = 0; old_right_lo = 0; old_right_hi = 0;
  endtask

  task automatic m_step();
    logic [N-1:0] nv;
    int vic;
    vic = m_victim();
    nv = mv & ~inval_i;
    m_done = 0;
    if (m_left > 0) begin
      nv[N-m_left] = 1'b0;
      m_left--;
      m_done = (m_left == 0);
      m_pend = 0;
    end else begin
      for (int e = 0; e < N; e++)
        if ((hit_i[e] && mv[e]) || (m_busy && e == m_gidx)) m_touch(e);
      if (m_busy) begin
        nv[m_gidx] = 1'b1;
        m_busy = 0;
        m_pend = m_pend | flush_i;
      end else if (m_pend || flush_i) begin
        m_left = N;
        m_pend = 0;
      end else if (alloc_req_i) begin
        m_busy = 1;
        m_gidx = vic;
      end
    end
    mv = nv;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    step();
    step();
    checks++;
    if (obs !== RST_OBS) begin
      errors++;
      $display("FAIL reset: gnt/idx/done/valid/full/empty=%b expected %b", obs, RST_OBS);
    end
  endtask

  task automatic test_fill();
    bit eg;
    alloc_req_i = 1'b1;
    rst_ni = 1'b1;
    for (int c = 2; c <= 8; c++) begin
      step();
      eg = (c % 2 == 0);
      checks++;
      if (alloc_gnt_o !== eg || (eg && alloc_idx_o !== 2'(c / 2 - 1))) begin
        errors++;
        $display("FAIL fill cycle %0d: gnt=%b idx=%0d expected gnt=%b idx=%0d", c, alloc_gnt_o, alloc_idx_o, eg, c / 2 - 1);
      end
    end
    step();
    checks++;
    if (full_o !== 1'b1 || valid_o !== 4'b1111) begin
      errors++;
      $display("FAIL fill_full: full=%b valid=%b expected 1 1111", full_o, valid_o);
    end
    step();
    checks++;
    if (alloc_gnt_o !== 1'b1 || alloc_idx_o !== 2'd0) begin
      errors++;
      $display("FAIL plru_5th: gnt=%b idx=%0d expected 1 0", alloc_gnt_o, alloc_idx_o);
    end
    step();
    step();
    checks++;
    if (alloc_gnt_o !== 1'b1 || alloc_idx_o !== 2'd2) begin
      errors++;
      $display("FAIL plru_6th: gnt=%b idx=%0d expected 1 2", alloc_gnt_o, alloc_idx_o);
    end
    alloc_req_i = 1'b0;
    step();
    checks++;
    if (alloc_gnt_o !== 1'b0 || full_o !== 1'b1) begin
      errors++;
      $display("FAIL fill_idle: gnt=%b full=%b expected 0 1", alloc_gnt_o, full_o);
    end
  endtask

  task automatic test_inval_pref();
    inval_i = 4'b0100;
    step();
    inval_i = '0;
    checks++;
    if (valid_o !== 4'b1011 || full_o !== 1'b0) begin
      errors++;
      $display("FAIL inval_clear: valid=%b full=%b expected 1011 0", valid_o, full_o);
    end
    alloc_req_i = 1'b1;
    step();
    alloc_req_i = 1'b0;
    checks++;
    if (alloc_gnt_o !== 1'b1 || alloc_idx_o !== 2'd2) begin
      errors++;
      $display("FAIL inval_pref: gnt=%b idx=%0d expected 1 2", alloc_gnt_o, alloc_idx_o);
    end
    step();
    checks++;
    if (full_o !== 1'b1) begin
      errors++;
      $display("FAIL inval_refull: full=%b expected 1", full_o);
    end
  endtask

  task automatic test_same_cycle();
    inval_i = 4'b0010;
    step();
    inval_i = '0;
    alloc_req_i = 1'b1;
    step();
    alloc_req_i = 1'b0;
    inval_i = 4'b0010;
    checks++;
    if (alloc_gnt_o !== 1'b1 || alloc_idx_o !== 2'd1) begin
      errors++;
      $display("FAIL same_cycle_gnt: gnt=%b idx=%0d expected 1 1", alloc_gnt_o, alloc_idx_o);
    end
    step();
    inval_i = '0;
    checks++;
    if (valid_o !== 4'b1111) begin
      errors++;
      $display("FAIL same_cycle_set_wins: valid=%b expected 1111", valid_o);
    end
  endtask

  task automatic test_flush();
    logic [N-1:0] ev;
    alloc_req_i = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    for (int k = 1; k <= N; k++) begin
      step();
      flush_i = (k == 2);
      ev = 4'(4'hF << k);
      checks++;
      if (alloc_gnt_o !== 1'b0 || flush_done_o !== (k == N) || valid_o !== ev) begin
        errors++;
        $display("FAIL flush k=%0d: gnt=%b done=%b valid=%b expected 0 %b %b", k, alloc_gnt_o, flush_done_o, valid_o, k == N, ev);
      end
    end
    flush_i = 1'b0;
    checks++;
    if (empty_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: empty=%b expected 1", empty_o);
    end
    step();
    alloc_req_i = 1'b0;
    checks++;
    if (alloc_gnt_o !== 1'b1 || alloc_idx_o !== 2'd0 || flush_done_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_then_grant: gnt=%b idx=%0d done=%b expected 1 0 0", alloc_gnt_o, alloc_idx_o, flush_done_o);
    end
    step();
    checks++;
    if (valid_o !== 4'b0001) begin
      errors++;
      $display("FAIL flush_absorbed: valid=%b expected 0001", valid_o);
    end
  endtask

  task automatic test_reset_abort();
    alloc_req_i = 1'b1;
    step();
    alloc_req_i = 1'b0;
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    step();
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (obs !== RST_OBS) begin
      errors++;
      $display("FAIL reset_mid_flush: obs=%b expected %b", obs, RST_OBS);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (flush_done_o !== 1'b0 || obs !== RST_OBS) begin
        errors++;
        $display("FAIL reset_hold %0d: obs=%b expected %b", k, obs, RST_OBS);
      end
    end
    rst_ni = 1'b1;
    alloc_req_i = 1'b1;
    step();
    alloc_req_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (obs !== RST_OBS) begin
      errors++;
      $display("FAIL reset_mid_grant: obs=%b expected %b", obs, RST_OBS);
    end
    step();
  endtask

  task automatic test_random();
    bit eg;
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      eg = m_busy;
      checks++;
      if (alloc_gnt_o !== eg || (eg && alloc_idx_o !== 2'(m_gidx)) || flush_done_o !== m_done ||
          valid_o !== mv || full_o !== (&mv) || empty_o !== (mv == '0)) begin
        errors++;
        $display("FAIL random cycle %0d: gnt=%b idx=%0d done=%b valid=%b expected gnt=%b idx=%0d done=%b valid=%b",
                 c, alloc_gnt_o, alloc_idx_o, flush_done_o, valid_o, eg, m_gidx, m_done, mv);
      end
      if (alloc_gnt_o) alloc_req_i = 1'b0;
      else if (!alloc_req_i) alloc_req_i = ($urandom_range(0, 2) == 0);
      hit_i   = N'($urandom);
      inval_i = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      flush_i = ($urandom_range(0, 39) == 0);
      m_step();
      step();
    end
    alloc_req_i = 1'b0; hit_i = '0; inval_i = '0; flush_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_inval_pref();
    test_same_cycle();
    test_flush();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
